updi_link_ctrl: RTL and testbench
=================================

// Module: updi_link_ctrl
// PURPOSE
//  Half-duplex link sequencer for the single-wire UPDI line. Sits between the
//  instruction layer and the UART TX/RX pair. Schedules the shared wire between
//  host transmit and target response, checks and discards the echo of every
//  transmitted byte, collects a counted number of response bytes, applies
//  timeouts, and generates BREAK for link recovery.
// PARAMETERS
//  RSP_LEN_BITS    8      width of per-command response byte count
//  TIMEOUT_CYCLES  65536  clk cycles allowed for an echo or for each response byte
//  BREAK_CYCLES    240    clk cycles line_brk is held (24 bit times at div 10)
// PORTS
//  clk          in   1             logic clock, all state on posedge
//  rst_n        in   1             asynchronous, active-low reset
//  cmd_data     in   8             byte to transmit
//  cmd_last     in   1             byte is the last of the command
//  cmd_rsp_len  in   RSP_LEN_BITS  response bytes expected after last byte (sampled with last)
//  cmd_valid    in   1             cmd_* valid
//  cmd_ready    out  1             byte accepted when cmd_valid && cmd_ready
//  brk_req      in   1             request BREAK (level, sampled each cycle)
//  tx_data      out  8             to uart_tx
//  tx_start     out  1             one-cycle pulse launching tx_data
//  tx_en        out  1             line driver enable (host owns wire)
//  line_brk     out  1             force line low (BREAK)
//  rx_data      in   8             from uart_rx
//  rx_data_valid in  1             one-cycle strobe from uart_rx
//  rx_error     in   1             one-cycle parity/frame error strobe from uart_rx
//  rsp_data     out  8             received response byte
//  rsp_valid    out  1             one-cycle strobe, no backpressure
//  err_echo     out  1             pulse: echo mismatch or rx_error on echo
//  err_rx       out  1             pulse: rx_error during response
//  err_timeout  out  1             pulse: echo or response timeout
//  busy         out  1             state != IDLE
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE; all registered outputs 0; counters 0.
//  cmd_ready = (state==IDLE || state==TX_NEXT) && !brk_req (combinational).
//  States: IDLE, TX_ECHO, TX_NEXT, RX_RSP, BREAK.
//  IDLE: tx_en=0. On cmd accept: latch byte/last/rsp_len; next cycle tx_start=1,
//   tx_data=byte, tx_en=1; go TX_ECHO, load timer=TIMEOUT_CYCLES.
//  TX_ECHO: tx_en=1. rx_data_valid && rx_data==sent byte -> echo OK:
//   !last -> TX_NEXT; last && rsp_len==0 -> IDLE; last && rsp_len>0 -> RX_RSP,
//   tx_en=0 same cycle, reload timer. Mismatch or rx_error -> err_echo, IDLE.
//   Timer reaching 0 -> err_timeout, IDLE.
//  TX_NEXT: tx_en held 1, no timeout; cmd accept behaves as in IDLE.
//  RX_RSP: each rx_data_valid -> rsp_data/rsp_valid registered 1 cycle later,
//   remaining count -1, timer reloaded; count reaching 0 -> IDLE. rx_error ->
//   err_rx, IDLE (remaining bytes dropped). Timer 0 -> err_timeout, IDLE.
//  BREAK: brk_req high in any state has priority over everything, aborts the
//   current command and enters BREAK (no error pulse). line_brk=1, tx_en=1 for
//   exactly BREAK_CYCLES cycles, then IDLE. brk_req during BREAK ignored; a
//   still-high brk_req on return to IDLE starts a new BREAK.
//  rx strobes in IDLE/TX_NEXT/BREAK ignored. rx_data_valid and rx_error in the
//   same cycle: treat as error. Timer decrement and rx strobe in same cycle:
//   strobe wins. Error strobes and rsp_valid are single-cycle, mutually exclusive.
//  Count arithmetic unsigned, RSP_LEN_BITS wide; no wrap (stops at 0).
// TESTING
//  1. Send 0x55,0x80 (last, rsp_len=1), echo both, rx 0x30 -> tx_start x2, rsp_valid
//     once with 0x30, busy falls, no err pulses.
//  2. Send 0x55 last rsp_len=0, echo 0x54 -> err_echo pulse, IDLE, tx_en=0.
//  3. last rsp_len=3, deliver 2 bytes then silence -> 2 rsp_valid,
//     err_timeout exactly TIMEOUT_CYCLES after 2nd byte.
//  4. brk_req pulse mid-RX_RSP -> line_brk high for 240 cycles, then IDLE,
//     no rsp_valid/err pulses.
//  5. rx_error during RX_RSP -> err_rx, IDLE; following command accepted normally.
//  6. rst_n low mid-TX_ECHO (async, off clock edge) -> outputs 0 immediately,
//     cmd_ready=1 after release.

Source files
------------

// File: rtl/updi_link_ctrl.sv
// Half-duplex UPDI link sequencer: drives TX bytes, discards and checks their
// echoes, collects a counted response, applies timeouts, and generates BREAK.
module updi_link_ctrl #(
    parameter int RSP_LEN_BITS   = 8,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int BREAK_CYCLES   = 240
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              cmd_data,
    input  logic                    cmd_last,
    input  logic [RSP_LEN_BITS-1:0] cmd_rsp_len,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    brk_req,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    output logic                    tx_en,
    output logic                    line_brk,
    input  logic [7:0]              rx_data,
    input  logic                    rx_data_valid,
    input  logic                    rx_error,
    output logic [7:0]              rsp_data,
    output logic                    rsp_valid,
    output logic                    err_echo,
    output logic                    err_rx,
    output logic                    err_timeout,
    output logic                    busy
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BRK_W = $clog2(BREAK_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [BRK_W-1:0] BRK_LOAD = BRK_W'(BREAK_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_TX_ECHO, S_TX_NEXT, S_RX_RSP, S_BREAK} state_t;

    state_t                  state, state_n;
    logic [7:0]              tx_data_n, rsp_data_n;
    logic                    tx_start_n, rsp_valid_n;
    logic                    err_echo_n, err_rx_n, err_timeout_n;
    logic                    last_q, last_n;
    logic [RSP_LEN_BITS-1:0] rem, rem_n;
    logic [TMR_W-1:0]        timer, timer_n;
    logic [BRK_W-1:0]        brk_cnt, brk_cnt_n;
    logic                    cmd_acc;

    // Wire ownership and status decode straight from the state register
    assign cmd_ready = (state == S_IDLE || state == S_TX_NEXT) && !brk_req;
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign tx_en     = (state == S_TX_ECHO) || (state == S_TX_NEXT) || (state == S_BREAK);
    assign line_brk  = (state == S_BREAK);
    assign busy      = (state != S_IDLE);

    // Next-state and next-output logic; BREAK request overrides everything
    always_comb begin
        state_n       = state;
        tx_data_n     = tx_data;
        tx_start_n    = 1'b0;
        last_n        = last_q;
        rem_n         = rem;
        timer_n       = timer;
        brk_cnt_n     = brk_cnt;
        rsp_data_n    = rsp_data;
        rsp_valid_n   = 1'b0;
        err_echo_n    = 1'b0;
        err_rx_n      = 1'b0;
        err_timeout_n = 1'b0;
        if (brk_req && state != S_BREAK) begin
            state_n   = S_BREAK;
            brk_cnt_n = BRK_LOAD;
        end else begin
            case (state)
                S_IDLE, S_TX_NEXT: begin
                    if (cmd_acc) begin
                        tx_data_n  = cmd_data;
                        tx_start_n = 1'b1;
                        last_n     = cmd_last;
                        rem_n      = cmd_rsp_len;
                        timer_n    = TMR_LOAD;
                        state_n    = S_TX_ECHO;
                    end
                end
                S_TX_ECHO: begin
                    // An rx strobe takes precedence over the timer in the same cycle
                    if (rx_error || (rx_data_valid && rx_data != tx_data)) begin
                        err_echo_n = 1'b1;
                        state_n    = S_IDLE;
                    end else if (rx_data_valid) begin
                        if (!last_q) begin
                            state_n = S_TX_NEXT;
                        end else if (rem == '0) begin
                            state_n = S_IDLE;
                        end else begin
                            timer_n = TMR_LOAD;
                            state_n = S_RX_RSP;
                        end
                    end else if (timer <= TMR_W'(1)) begin
                        timer_n       = '0;
                        err_timeout_n = 1'b1;
                        state_n       = S_IDLE;
                    end else begin
                        timer_n = timer - TMR_W'(1);
                    end
                end
                S_RX_RSP: begin
                    if (rx_error) begin
                        err_rx_n = 1'b1;
                        state_n  = S_IDLE;
                    end else if (rx_data_valid) begin
                        rsp_data_n  = rx_data;
                        rsp_valid_n = 1'b1;
                        timer_n     = TMR_LOAD;
                        if (rem <= RSP_LEN_BITS'(1)) begin
                            rem_n   = '0;
                            state_n = S_IDLE;
                        end else begin
                            rem_n = rem - RSP_LEN_BITS'(1);
                        end
                    end else if (timer <= TMR_W'(1)) begin
                        timer_n       = '0;
                        err_timeout_n = 1'b1;
                        state_n       = S_IDLE;
                    end else begin
                        timer_n = timer - TMR_W'(1);
                    end
                end
                S_BREAK: begin
                    if (brk_cnt <= BRK_W'(1)) begin
                        brk_cnt_n = '0;
                        state_n   = S_IDLE;
                    end else begin
                        brk_cnt_n = brk_cnt - BRK_W'(1);
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            last_q      <= 1'b0;
            rem         <= '0;
            timer       <= '0;
            brk_cnt     <= '0;
            rsp_data    <= '0;
            rsp_valid   <= 1'b0;
            err_echo    <= 1'b0;
            err_rx      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            tx_data     <= tx_data_n;
            tx_start    <= tx_start_n;
            last_q      <= last_n;
            rem         <= rem_n;
            timer       <= timer_n;
            brk_cnt     <= brk_cnt_n;
            rsp_data    <= rsp_data_n;
            rsp_valid   <= rsp_valid_n;
            err_echo    <= err_echo_n;
            err_rx      <= err_rx_n;
            err_timeout <= err_timeout_n;
        end
    end
endmodule

// File: tb/tb_updi_link_ctrl.sv
// Scoreboard bench for updi_link_ctrl: expected TX and response bytes are
// queued at stimulus time and popped by a negedge monitor.
module tb_updi_link_ctrl;
    localparam int T = 100;
    localparam int B = 240;

    logic       clk, rst_n;
    logic [7:0] cmd_data;
    logic       cmd_last;
    logic [7:0] cmd_rsp_len;
    logic       cmd_valid, cmd_ready, brk_req;
    logic [7:0] tx_data;
    logic       tx_start, tx_en, line_brk;
    logic [7:0] rx_data;
    logic       rx_data_valid, rx_error;
    logic [7:0] rsp_data;
    logic       rsp_valid, err_echo, err_rx, err_timeout, busy;

    updi_link_ctrl #(.RSP_LEN_BITS(8), .TIMEOUT_CYCLES(T), .BREAK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_data(cmd_data), .cmd_last(cmd_last), .cmd_rsp_len(cmd_rsp_len),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .brk_req(brk_req),
        .tx_data(tx_data), .tx_start(tx_start), .tx_en(tx_en), .line_brk(line_brk),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_error(rx_error),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .err_echo(err_echo),
        .err_rx(err_rx), .err_timeout(err_timeout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0, n_miss = 0;
    int cyc = 0;
    int n_txs = 0, n_rsp = 0, n_echo = 0, n_rx = 0, n_to = 0, n_brk = 0;
    int t_rsp = 0, t_to = 0;
    logic [7:0] txq[$];
    logic [7:0] rspq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops scoreboard queues, counts pulses and break cycles
    always @(negedge clk) begin
        if (tx_start) begin
            n_txs++;
            if (txq.size() == 0) chk("tx_unexpected", 32'(tx_data), 32'hffff_ffff);
            else chk("tx_data", 32'(tx_data), 32'(txq.pop_front()));
        end
        if (rsp_valid) begin
            n_rsp++;
            t_rsp = cyc;
            if (rspq.size() == 0) chk("rsp_unexpected", 32'(rsp_data), 32'hffff_ffff);
            else chk("rsp_data", 32'(rsp_data), 32'(rspq.pop_front()));
        end
        if (err_echo) n_echo++;
        if (err_rx) n_rx++;
        if (err_timeout) begin n_to++; t_to = cyc; end
        if (line_brk) n_brk++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic [7:0] len);
        int n;
        tick(1);
        n = 0;
        while (!cmd_ready && n < 50) begin tick(1); n++; end
        if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_data = d; cmd_last = last; cmd_rsp_len = len; cmd_valid = 1'b1;
        txq.push_back(d);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic rx_strobe(input logic [7:0] d, input logic v, input logic e);
        tick(1);
        rx_data = d; rx_data_valid = v; rx_error = e;
        @(posedge clk); #1;
        rx_data_valid = 1'b0; rx_error = 1'b0;
    endtask

    task automatic echo(input logic [7:0] d);
        tick(2);
        rx_strobe(d, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_rsp, s_tx, s_brk, s_echo, s_to, n;
        rst_n = 1'b0; brk_req = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_last = 1'b0;
        cmd_rsp_len = '0; rx_data = '0; rx_data_valid = 1'b0; rx_error = 1'b0;
        tick(3);
        chk("rst_tx_en", 32'(tx_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_line_brk", 32'(line_brk), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        rst_n = 1'b1;
        tick(2);

        // 1: two-byte command, one response byte
        send_byte(8'h55, 1'b0, 8'd0);
        tick(1);
        chk("t1_txen_echo", 32'(tx_en), 1);
        echo(8'h55);
        tick(1);
        chk("t1_txen_next", 32'(tx_en), 1);
        chk("t1_busy_next", 32'(busy), 1);
        send_byte(8'h80, 1'b1, 8'd1);
        echo(8'h80);
        tick(1);
        chk("t1_txen_rsp", 32'(tx_en), 0);
        rspq.push_back(8'h30);
        rx_strobe(8'h30, 1'b1, 1'b0);
        tick(2);
        chk("t1_tx_starts", 32'(n_txs), 2);
        chk("t1_rsp_cnt", 32'(n_rsp), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_errs", 32'(n_echo + n_rx + n_to), 0);

        // 2: echo mismatch
        send_byte(8'h55, 1'b1, 8'd0);
        echo(8'h54);
        tick(1);
        chk("t2_err_echo", 32'(n_echo), 1);
        chk("t2_busy", 32'(busy), 0);
        chk("t2_tx_en", 32'(tx_en), 0);

        // 3: response timeout after second of three bytes
        s_rsp = n_rsp;
        send_byte(8'hA0, 1'b1, 8'd3);
        echo(8'hA0);
        rspq.push_back(8'h11); rx_strobe(8'h11, 1'b1, 1'b0);
        tick(3);
        rspq.push_back(8'h22); rx_strobe(8'h22, 1'b1, 1'b0);
        n = 0;
        while (n_to == 0 && n < T + 20) begin tick(1); n++; end
        chk("t3_timeout_cnt", 32'(n_to), 1);
        chk("t3_timeout_dist", 32'(t_to - t_rsp), 32'(T));
        chk("t3_rsp_cnt", 32'(n_rsp - s_rsp), 2);
        chk("t3_busy", 32'(busy), 0);

        // 4: BREAK mid-response; rx strobes during BREAK are ignored
        s_rsp = n_rsp; s_brk = n_brk; s_echo = n_echo; s_to = n_to;
        send_byte(8'h24, 1'b1, 8'd2);
        echo(8'h24);
        rspq.push_back(8'h5A); rx_strobe(8'h5A, 1'b1, 1'b0);
        tick(1);
        brk_req = 1'b1;
        @(posedge clk); #1;
        brk_req = 1'b0;
        chk("t4_line_brk", 32'(line_brk), 1);
        tick(10);
        rx_strobe(8'h77, 1'b1, 1'b0);
        tick(B + 20);
        chk("t4_brk_cycles", 32'(n_brk - s_brk), 32'(B));
        chk("t4_busy", 32'(busy), 0);
        chk("t4_rsp_cnt", 32'(n_rsp - s_rsp), 1);
        chk("t4_errs", 32'(n_echo - s_echo + n_to - s_to + n_rx), 0);

        // 5: rx_error during response, then a normal command
        s_tx = n_txs; s_echo = n_echo;
        send_byte(8'h3C, 1'b1, 8'd2);
        echo(8'h3C);
        rx_strobe(8'h99, 1'b1, 1'b1);
        tick(1);
        chk("t5_err_rx", 32'(n_rx), 1);
        chk("t5_busy", 32'(busy), 0);
        send_byte(8'hC3, 1'b1, 8'd0);
        echo(8'hC3);
        tick(1);
        chk("t5_tx_starts", 32'(n_txs - s_tx), 2);
        chk("t5_no_echo_err", 32'(n_echo - s_echo), 0);
        chk("t5_busy_after", 32'(busy), 0);

        // 6: async reset during TX_ECHO
        s_to = n_to;
        send_byte(8'h42, 1'b1, 8'd0);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_tx_en", 32'(tx_en), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_tx_start", 32'(tx_start), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        tick(1);
        chk("t6_cmd_ready", 32'(cmd_ready), 1);
        tick(T + 10);
        chk("t6_no_timeout", 32'(n_to - s_to), 0);
        chk("end_txq_empty", 32'(txq.size()), 0);
        chk("end_rspq_empty", 32'(rspq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
